// File: rtl/flash_avmm_responder_if.sv
// -----------------------------------------------------------------------------
// flash_avmm_responder_if
//
// Avalon-MM read-only bus between the flash read master and the responder that
// stands in for the external flash controller.
//
// Handshake semantics (read-only Avalon-MM with pipelined read data):
//   - The master raises flash_mem_read with a stable-enough address/byteenable
//     and keeps read high until it samples flash_mem_waitrequest low on a rising
//     edge. A read is transferred on exactly that edge: read=1 and
//     waitrequest=0 in the same cycle. Address and byteenable may change while
//     waitrequest is high; only the values present in the transfer cycle count.
//   - Data returns later as a one-cycle flash_mem_readdatavalid pulse carrying
//     flash_mem_readdata, in the same order the reads were transferred. There
//     is no back-pressure on the return path. readdata is 0 whenever
//     readdatavalid is 0.
//
// Signals:
//   flash_mem_read          master -> slave  read request
//   flash_mem_address       master -> slave  23-bit word address
//   flash_mem_byteenable    master -> slave  byte lanes requested
//   flash_mem_waitrequest   slave  -> master stall, low on the transfer cycle
//   flash_mem_readdata      slave  -> master returned word
//   flash_mem_readdatavalid slave  -> master one-cycle return strobe
// -----------------------------------------------------------------------------
interface flash_avmm_responder_if;
  logic        flash_mem_read;
  logic [22:0] flash_mem_address;
  logic [3:0]  flash_mem_byteenable;
  logic        flash_mem_waitrequest;
  logic [31:0] flash_mem_readdata;
  logic        flash_mem_readdatavalid;

  modport master (
    output flash_mem_read,
    output flash_mem_address,
    output flash_mem_byteenable,
    input  flash_mem_waitrequest,
    input  flash_mem_readdata,
    input  flash_mem_readdatavalid
  );

  modport slave (
    input  flash_mem_read,
    input  flash_mem_address,
    input  flash_mem_byteenable,
    output flash_mem_waitrequest,
    output flash_mem_readdata,
    output flash_mem_readdatavalid
  );
endinterface

// File: rtl/flash_avmm_responder.sv
// -----------------------------------------------------------------------------
// flash_avmm_responder
//
// Read-only Avalon-MM slave that answers the flash read master in place of the
// external flash controller. Each request is stalled for WAIT_CYCLES cycles,
// granted for one cycle, and (if the master still reads in that cycle)
// answered READ_LATENCY cycles later. The returned word is a pure function of
// the address so every sample can be checked without a flash image:
//   A <= MAX_ADDRESS : {A[15:0] + 1, A[15:0]}
//   A >  MAX_ADDRESS : 32'hDEADBEEF
// with disabled byte lanes forced to 8'h00.
//
// Parameters:
//   WAIT_CYCLES   wait states before each grant (0 allowed)
//   READ_LATENCY  cycles from acceptance to readdatavalid (1..8)
//   MAX_PENDING   accepted-but-unreturned reads allowed (1..READ_LATENCY)
//   MAX_ADDRESS   highest word address that returns pattern data
//
// Ports:
//   CLK50MHZ        clock, rising edge
//   reset_n         asynchronous active-low reset
//   bus             Avalon-MM slave side (flash_avmm_responder_if.slave)
//   pending         reads in flight (accepted, data not yet returned)
//   accepted_count  total accepted reads, wraps at 16 bits
//   state_dbg       current FSM state (0 IDLE, 1 STALL, 2 GRANT)
// -----------------------------------------------------------------------------
module flash_avmm_responder #(
  parameter int          WAIT_CYCLES  = 2,
  parameter int          READ_LATENCY = 3,
  parameter int          MAX_PENDING  = 2,
  parameter logic [22:0] MAX_ADDRESS  = 23'h7FFFF
) (
  input  logic                           CLK50MHZ,
  input  logic                           reset_n,
  flash_avmm_responder_if.slave          bus,
  output logic [$clog2(MAX_PENDING):0]   pending,
  output logic [15:0]                    accepted_count,
  output logic [1:0]                     state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_STALL = 2'd1,
    S_GRANT = 2'd2
  } state_t;

  localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam int PW = $clog2(MAX_PENDING) + 1;
  localparam logic [CW-1:0] WAIT_INIT = CW'(WAIT_CYCLES);
  localparam logic [PW-1:0] PEND_MAX  = PW'(MAX_PENDING);

  state_t          state;
  logic [CW-1:0]   wait_cnt;
  logic            accept;
  logic            retire;
  logic            room;

  // Latency pipeline: stage i holds a read accepted i+1 edges ago.
  logic [READ_LATENCY-1:0] pipe_valid;
  logic [22:0]             pipe_addr [READ_LATENCY];
  logic [3:0]              pipe_be   [READ_LATENCY];

  // Value about to enter the last stage; the registered output is built from
  // it so readdatavalid rises in the same cycle the last stage becomes valid.
  logic        tail_valid;
  logic [22:0] tail_addr;
  logic [3:0]  tail_be;

  assign accept    = (state == S_GRANT) && bus.flash_mem_read;
  assign retire    = pipe_valid[READ_LATENCY-1];
  assign room      = (pending < PEND_MAX);
  assign state_dbg = state;

  // ---------------------------------------------------------------------------
  // Data function
  // ---------------------------------------------------------------------------
  function automatic logic [31:0] word_for(input logic [22:0] addr,
                                           input logic [3:0]  be);
    logic [31:0] w;
    if (addr <= MAX_ADDRESS) begin
      w = {addr[15:0] + 16'h0001, addr[15:0]};
    end else begin
      w = 32'hDEADBEEF;
    end
    for (int i = 0; i < 4; i++) begin
      if (!be[i]) begin
        w[8*i +: 8] = 8'h00;
      end
    end
    return w;
  endfunction

  // ---------------------------------------------------------------------------
  // Grant FSM, waitrequest and acceptance counter
  // ---------------------------------------------------------------------------
  // waitrequest is registered: it is driven low on the edge that enters GRANT
  // and high on every other edge, so it is low for exactly the GRANT cycle.
  // The pending check is made on the transition into GRANT; pending cannot
  // grow between that decision and the grant since only GRANT accepts.
  always_ff @(posedge CLK50MHZ or negedge reset_n) begin
    if (!reset_n) begin
      state                     <= S_IDLE;
      wait_cnt                  <= '0;
      bus.flash_mem_waitrequest <= 1'b1;
      accepted_count            <= 16'h0000;
    end else begin
      if (accept) begin
        accepted_count <= accepted_count + 16'h0001;
      end

      case (state)
        S_IDLE: begin
          bus.flash_mem_waitrequest <= 1'b1;
          wait_cnt                  <= '0;
          if (bus.flash_mem_read) begin
            if ((WAIT_CYCLES == 0) && room) begin
              state                     <= S_GRANT;
              bus.flash_mem_waitrequest <= 1'b0;
            end else begin
              // With zero wait states and a full pipeline this parks in STALL
              // with the counter already at 0 until a read retires.
              state    <= S_STALL;
              wait_cnt <= WAIT_INIT;
            end
          end
        end

        S_STALL: begin
          bus.flash_mem_waitrequest <= 1'b1;
          if (!bus.flash_mem_read) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
          end else if ((wait_cnt <= CW'(1)) && room) begin
            // Counter reaches (or already sits at) zero this cycle.
            state                     <= S_GRANT;
            wait_cnt                  <= '0;
            bus.flash_mem_waitrequest <= 1'b0;
          end else if (wait_cnt != '0) begin
            wait_cnt <= wait_cnt - CW'(1);
          end
        end

        S_GRANT: begin
          // One grant per request; a read left low here wastes the grant.
          state                     <= S_IDLE;
          wait_cnt                  <= '0;
          bus.flash_mem_waitrequest <= 1'b1;
        end

        default: begin
          state                     <= S_IDLE;
          wait_cnt                  <= '0;
          bus.flash_mem_waitrequest <= 1'b1;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Latency pipeline and in-flight count
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK50MHZ or negedge reset_n) begin
    if (!reset_n) begin
      pipe_valid <= '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        pipe_addr[i] <= '0;
        pipe_be[i]   <= '0;
      end
      pending <= '0;
    end else begin
      for (int i = READ_LATENCY - 1; i > 0; i--) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_addr[i]  <= pipe_addr[i-1];
        pipe_be[i]    <= pipe_be[i-1];
      end
      pipe_valid[0] <= accept;
      if (accept) begin
        pipe_addr[0] <= bus.flash_mem_address;
        pipe_be[0]   <= bus.flash_mem_byteenable;
      end

      // Accept and retire on the same edge cancel out.
      case ({accept, retire})
        2'b10:   pending <= pending + PW'(1);
        2'b01:   pending <= pending - PW'(1);
        default: pending <= pending;
      endcase
    end
  end

  generate
    if (READ_LATENCY == 1) begin : g_tail_direct
      assign tail_valid = accept;
      assign tail_addr  = bus.flash_mem_address;
      assign tail_be    = bus.flash_mem_byteenable;
    end else begin : g_tail_pipe
      assign tail_valid = pipe_valid[READ_LATENCY-2];
      assign tail_addr  = pipe_addr[READ_LATENCY-2];
      assign tail_be    = pipe_be[READ_LATENCY-2];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Registered return port: data and strobe change together, data is zero
  // whenever the strobe is low.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK50MHZ or negedge reset_n) begin
    if (!reset_n) begin
      bus.flash_mem_readdatavalid <= 1'b0;
      bus.flash_mem_readdata      <= 32'h0000_0000;
    end else begin
      bus.flash_mem_readdatavalid <= tail_valid;
      bus.flash_mem_readdata      <= tail_valid ? word_for(tail_addr, tail_be)
                                                : 32'h0000_0000;
    end
  end

endmodule

// File: tb/tb_flash_avmm_responder.sv
// -----------------------------------------------------------------------------
// tb_flash_avmm_responder
//
// Two responders share one clock and reset:
//   dut_a : defaults (WAIT_CYCLES=2, READ_LATENCY=3, MAX_PENDING=2)
//   dut_b : WAIT_CYCLES=0, READ_LATENCY=4, MAX_PENDING=1 (back-pressure case)
// Drivers push the hand-computed word and its expected return cycle into a
// per-DUT queue at acceptance; independent monitors pop and compare on every
// readdatavalid pulse. Cycle k is the interval after the k-th rising edge.
// -----------------------------------------------------------------------------
module tb_flash_avmm_responder;

  localparam int A_WAIT = 2;
  localparam int A_LAT  = 3;
  localparam int B_WAIT = 0;
  localparam int B_LAT  = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  flash_avmm_responder_if a_if ();
  flash_avmm_responder_if b_if ();

  logic [1:0]  pending_a;
  logic [0:0]  pending_b;
  logic [15:0] count_a;
  logic [15:0] count_b;
  logic [1:0]  state_a;
  logic [1:0]  state_b;

  flash_avmm_responder #(
    .WAIT_CYCLES(A_WAIT), .READ_LATENCY(A_LAT), .MAX_PENDING(2),
    .MAX_ADDRESS(23'h7FFFF)
  ) dut_a (
    .CLK50MHZ(clk), .reset_n(reset_n), .bus(a_if),
    .pending(pending_a), .accepted_count(count_a), .state_dbg(state_a)
  );

  flash_avmm_responder #(
    .WAIT_CYCLES(B_WAIT), .READ_LATENCY(B_LAT), .MAX_PENDING(1),
    .MAX_ADDRESS(23'h7FFFF)
  ) dut_b (
    .CLK50MHZ(clk), .reset_n(reset_n), .bus(b_if),
    .pending(pending_b), .accepted_count(count_b), .state_dbg(state_b)
  );

  // ---------------- scoreboard ----------------
  logic [31:0] exp_a_q[$];
  int          exp_a_cyc_q[$];
  logic [31:0] exp_b_q[$];
  int          exp_b_cyc_q[$];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  logic [31:0] a_exp_data;
  int          a_exp_cyc;
  always @(negedge clk) begin
    if (a_if.flash_mem_readdatavalid === 1'b1) begin
      if (exp_a_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL a_unexpected_valid: got data %h expected no strobe (cycle %0d)",
                 a_if.flash_mem_readdata, cyc);
      end else begin
        a_exp_data = exp_a_q.pop_front();
        a_exp_cyc  = exp_a_cyc_q.pop_front();
        check("a_readdata", a_if.flash_mem_readdata, a_exp_data);
        check("a_valid_cycle", cyc, a_exp_cyc);
      end
    end else begin
      check("a_idle_readdata_zero", a_if.flash_mem_readdata, 32'h0);
    end
  end

  logic [31:0] b_exp_data;
  int          b_exp_cyc;
  int          pend_b_model = 0;
  always @(negedge clk) begin
    if (!reset_n) begin
      pend_b_model = 0;
    end else begin
      check("b_pending", {31'd0, pending_b}, pend_b_model);
      if (b_if.flash_mem_readdatavalid === 1'b1) begin
        if (exp_b_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL b_unexpected_valid: got data %h expected no strobe (cycle %0d)",
                   b_if.flash_mem_readdata, cyc);
        end else begin
          b_exp_data = exp_b_q.pop_front();
          b_exp_cyc  = exp_b_cyc_q.pop_front();
          check("b_readdata", b_if.flash_mem_readdata, b_exp_data);
          check("b_valid_cycle", cyc, b_exp_cyc);
        end
      end else begin
        check("b_idle_readdata_zero", b_if.flash_mem_readdata, 32'h0);
      end
      if (b_if.flash_mem_read && !b_if.flash_mem_waitrequest) pend_b_model++;
      if (b_if.flash_mem_readdatavalid === 1'b1) pend_b_model--;
      check("b_in_flight_le_1", {31'd0, (pend_b_model <= 1)}, 32'd1);
    end
  end

  // ---------------- driver tasks ----------------
  // Called just after a rising edge. Holds read until granted; with chg=1 the
  // first cycle carries inverted address/byteenable that must not be captured.
  task automatic a_read(input logic [22:0] addr, input logic [3:0] be,
                        input logic [31:0] exp, input bit chg);
    int c0;
    int g;
    bit got;
    c0  = cyc;
    g   = 0;
    got = 1'b0;
    a_if.flash_mem_read       = 1'b1;
    a_if.flash_mem_address    = chg ? ~addr : addr;
    a_if.flash_mem_byteenable = chg ? ~be : be;
    for (int t = 0; t < 40 && !got; t++) begin
      @(negedge clk);
      if (a_if.flash_mem_waitrequest === 1'b0) begin
        got = 1'b1;
        g   = cyc;
        exp_a_q.push_back(exp);
        exp_a_cyc_q.push_back(g + A_LAT);
      end
      @(posedge clk);
      #1;
      a_if.flash_mem_address    = addr;
      a_if.flash_mem_byteenable = be;
    end
    a_if.flash_mem_read = 1'b0;
    check("a_grant_seen", {31'd0, got}, 32'd1);
    if (got) check("a_grant_cycle", g, c0 + A_WAIT + 1);
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_a_waitrequest"}, {31'd0, a_if.flash_mem_waitrequest}, 32'd1);
    check({tag, "_a_readdata"}, a_if.flash_mem_readdata, 32'd0);
    check({tag, "_a_readdatavalid"}, {31'd0, a_if.flash_mem_readdatavalid}, 32'd0);
    check({tag, "_a_pending"}, {30'd0, pending_a}, 32'd0);
    check({tag, "_a_count"}, {16'd0, count_a}, 32'd0);
    check({tag, "_b_waitrequest"}, {31'd0, b_if.flash_mem_waitrequest}, 32'd1);
    check({tag, "_b_pending"}, {31'd0, pending_b}, 32'd0);
    check({tag, "_b_count"}, {16'd0, count_b}, 32'd0);
  endtask

  // ---------------- directed vectors ----------------
  logic [22:0] v_addr [7] = '{23'h00010, 23'h7FFFF, 23'h080000, 23'h012345,
                              23'h07ABCD, 23'h7FFFF, 23'h7FFFFF};
  logic [3:0]  v_be   [7] = '{4'b0011, 4'hF, 4'hF, 4'b1010,
                              4'b0101, 4'b0110, 4'b1100};
  logic [31:0] v_exp  [7] = '{32'h0000_0010, 32'h0000_FFFF, 32'hDEAD_BEEF,
                              32'h2300_2300, 32'h00CE_00CD, 32'h0000_FF00,
                              32'hDEAD_0000};
  bit          v_chg  [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

  logic [22:0] b_addr [3] = '{23'h00020, 23'h7FFFE, 23'h0FFFFF};
  logic [31:0] b_exp  [3] = '{32'h0021_0020, 32'hFFFF_FFFE, 32'hDEAD_BEEF};

  // ---------------- main sequence ----------------
  initial begin
    int g_b [3];
    int c0;
    int k;
    bit wr_low;

    a_if.flash_mem_read       = 1'b0;
    a_if.flash_mem_address    = '0;
    a_if.flash_mem_byteenable = '0;
    b_if.flash_mem_read       = 1'b0;
    b_if.flash_mem_address    = '0;
    b_if.flash_mem_byteenable = '0;
    reset_n = 1'b0;

    // Reset behaviour: while low and after the first edge after release.
    repeat (3) @(negedge clk);
    reset_checks("rst_low");
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset_checks("rst_release");
    @(posedge clk);
    #1;

    // Single default read: grant in cycle 3, data in cycle 6.
    a_read(23'h00010, 4'hF, 32'h0011_0010, 1'b0);
    @(negedge clk);
    check("a_pending_after_accept", {30'd0, pending_a}, 32'd1);
    check("a_count_after_first", {16'd0, count_a}, 32'd1);
    check("a_wait_high_after_grant", {31'd0, a_if.flash_mem_waitrequest}, 32'd1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("a_pending_after_return", {30'd0, pending_a}, 32'd0);
    @(posedge clk);
    #1;

    // Back-to-back masking / wrap / out-of-range / mid-stall change vectors.
    for (int i = 0; i < 7; i++) begin
      a_read(v_addr[i], v_be[i], v_exp[i], v_chg[i]);
    end
    repeat (6) @(posedge clk);
    #1;
    check("a_count_after_vectors", {16'd0, count_a}, 32'd8);

    // Wasted grant: read drops in the GRANT cycle.
    a_if.flash_mem_read       = 1'b1;
    a_if.flash_mem_address    = 23'h00010;
    a_if.flash_mem_byteenable = 4'hF;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    a_if.flash_mem_read = 1'b0;
    @(negedge clk);
    check("a_wasted_grant_wait_low", {31'd0, a_if.flash_mem_waitrequest}, 32'd0);
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("a_count_after_waste", {16'd0, count_a}, 32'd8);
    check("a_pending_after_waste", {30'd0, pending_a}, 32'd0);

    // Read abandoned during STALL: no grant follows.
    @(posedge clk);
    #1 a_if.flash_mem_read = 1'b1;
    @(posedge clk);
    #1 a_if.flash_mem_read = 1'b0;
    wr_low = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (a_if.flash_mem_waitrequest !== 1'b1) wr_low = 1'b1;
    end
    check("a_abort_no_grant", {31'd0, wr_low}, 32'd0);
    check("a_count_after_abort", {16'd0, count_a}, 32'd8);
    @(posedge clk);
    #1;

    // Back-pressure on dut_b: read held high across three transfers.
    c0 = cyc;
    k  = 0;
    b_if.flash_mem_read       = 1'b1;
    b_if.flash_mem_address    = b_addr[0];
    b_if.flash_mem_byteenable = 4'hF;
    for (int t = 0; t < 80 && k < 3; t++) begin
      @(negedge clk);
      if (b_if.flash_mem_waitrequest === 1'b0) begin
        g_b[k] = cyc;
        exp_b_q.push_back(b_exp[k]);
        exp_b_cyc_q.push_back(cyc + B_LAT);
        k++;
      end
      @(posedge clk);
      #1;
      if (k < 3) b_if.flash_mem_address = b_addr[k];
    end
    b_if.flash_mem_read = 1'b0;
    check("b_all_granted", k, 3);
    if (k == 3) begin
      check("b_first_grant_cycle", g_b[0], c0 + B_WAIT + 1);
      for (int i = 1; i < 3; i++) begin
        check("b_grant_after_return", {31'd0, (g_b[i] > g_b[i-1] + B_LAT)}, 32'd1);
        check("b_grant_not_starved", {31'd0, (g_b[i] <= g_b[i-1] + B_LAT + 4)}, 32'd1);
      end
    end
    repeat (10) @(posedge clk);
    #1;
    check("b_count_after_burst", {16'd0, count_b}, 32'd3);

    // Reset in cycle 4 of a default read: the in-flight read is discarded.
    a_read(23'h00010, 4'hF, 32'h0011_0010, 1'b0);
    reset_n = 1'b0;
    exp_a_q.delete();
    exp_a_cyc_q.delete();
    @(negedge clk);
    reset_checks("rst_mid");
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    a_read(23'h00010, 4'hF, 32'h0011_0010, 1'b0);
    repeat (6) @(posedge clk);
    #1;
    check("a_count_after_reset_read", {16'd0, count_a}, 32'd1);

    check("a_queue_drained", exp_a_q.size(), 32'd0);
    check("b_queue_drained", exp_b_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

endmodule
